// File: rtl/bus_decoder.sv
// bus_decoder: 6502 address decode, read-data mux, per-region read wait states and sticky unmapped-access error
module bus_decoder #(
  parameter int AW = 16,
  parameter int DW = 8,
  parameter int NREG = 4,
  parameter logic [NREG*AW-1:0] BASE = {NREG{16'h0000}},
  parameter logic [NREG*AW-1:0] MASK = {NREG{16'hFFFF}},
  parameter logic [NREG*4-1:0] WAIT = {NREG{4'd0}},
  parameter logic [DW-1:0] DEFAULT_DATA = 8'hFF
) (
  input  logic clk,
  input  logic reset,
  input  logic [AW-1:0] AB,
  input  logic WE,
  output logic [NREG-1:0] cs,
  output logic [NREG-1:0] rd_sel,
  input  logic [NREG*DW-1:0] rd_data,
  output logic [DW-1:0] DI,
  output logic RDY,
  output logic bus_err,
  output logic [AW-1:0] err_addr,
  input  logic err_clr
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  state_t state, state_nxt;
  logic [NREG-1:0] hit;
  logic [3:0] w, cnt, cnt_nxt;
  logic [DW-1:0] mux;
  logic rdy_c, unmapped;
  for (genvar i = 0; i < NREG; i++) begin : g_hit
    assign hit[i] = (AB & MASK[i*AW +: AW]) == BASE[i*AW +: AW];
  end
  // isolate the lowest set bit so the lowest-index region wins
  assign cs = hit & (~hit + NREG'(1));
  always_comb begin
    w = '0;
    mux = '0;
    for (int i = 0; i < NREG; i++) begin
      w = w | (cs[i] ? WAIT[i*4 +: 4] : 4'd0);
      mux = mux | (rd_sel[i] ? rd_data[i*DW +: DW] : '0);
    end
  end
  assign DI = |rd_sel ? mux : DEFAULT_DATA;
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    rdy_c = 1'b1;
    case (state)
      S_IDLE: if (!WE && w != 4'd0) begin
        rdy_c = 1'b0;
        cnt_nxt = w - 4'd1;
        state_nxt = (w == 4'd1) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        rdy_c = 1'b0;
        cnt_nxt = cnt - 4'd1;
        state_nxt = (cnt == 4'd1) ? S_DONE : S_WAIT;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end
  assign RDY = reset | rdy_c;
  assign unmapped = ~|hit & RDY;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      rd_sel <= '0;
      bus_err <= 1'b0;
      err_addr <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      rd_sel <= cs & {NREG{~WE}};
      if (unmapped) begin
        bus_err <= 1'b1;
        if (!bus_err || err_clr) err_addr <= AB;
      end else if (err_clr) begin
        bus_err <= 1'b0;
      end
    end
  end
endmodule

// File: doc/bus_decoder.md
# bus_decoder

Parametrised address decoder and read-data multiplexer for the 6502 system bus. It replaces hand-written per-peripheral chip-select assigns and registered read selects in the top level with one block. It adds per-region read wait states (driving CPU `RDY`) and a sticky unmapped-access error. It sits between the CPU core and all memories and peripherals on the CPU clock.

## Interface
Parameters:
- `AW`, 16, address width.
- `DW`, 8, data width.
- `NREG`, 4, number of decoded regions, 1..8.
- `BASE`, `{NREG{16'h0000}}`, packed `NREG*AW`; region i base in bits `[i*AW +: AW]`.
- `MASK`, `{NREG{16'hFFFF}}`, packed `NREG*AW`; region i compare mask.
- `WAIT`, `{NREG{4'd0}}`, packed `NREG*4`; read wait states for region i, 0..15.
- `DEFAULT_DATA`, `8'hFF`, `DI` value when no region is read-selected.

Ports:
- `clk` in 1: CPU clock; one clock; everything here is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `AB` in AW: CPU address.
- `WE` in 1: CPU write enable, 1 = write.
- `cs` out NREG: one-hot combinational chip selects to peripherals.
- `rd_sel` out NREG: registered read select (`cs & ~WE`), drives peripheral output enables.
- `rd_data` in `NREG*DW`: peripheral read data, region i in `[i*DW +: DW]`.
- `DI` out DW: read data to CPU.
- `RDY` out 1: CPU ready; low stalls the CPU.
- `bus_err` out 1: sticky unmapped-access flag.
- `err_addr` out AW: address of the first unmapped access since the last clear.
- `err_clr` in 1: one-cycle pulse that clears `bus_err`.

## Operation
- Match: `hit_i = ((AB & MASK_i) == BASE_i)`. Lowest index wins on overlap. `cs` is one-hot or all-zero and purely combinational from `AB`.
- `rd_sel <= cs & ~WE` on every edge. `rd_sel` is not gated by `RDY`.
- `DI`: combinational mux on `rd_sel`, giving slice i of `rd_data` when `rd_sel[i]` is set, else `DEFAULT_DATA`.
- Wait FSM states: IDLE, WAIT, DONE. Counter `cnt` is 4 bits.
  - IDLE: on a slow read (`~WE`, winning region n has `WAIT_n` = W > 0), `RDY` = 0 combinationally. Load `cnt` = W−1. Next state is DONE if W = 1, else WAIT.
  - WAIT: `RDY` = 0 and `cnt` decrements. When `cnt` == 1, next state is DONE.
  - DONE: `RDY` = 1, which completes the access. Next state is IDLE.
  - Net effect: `RDY` is low for exactly W consecutive cycles, starting in the cycle the address first appears.
- Writes and zero-wait reads never drop `RDY`.
- The CPU holds `AB`/`WE` while `RDY` = 0. The block does not re-check the address in WAIT or DONE.
- Back-to-back slow reads: DONE→IDLE. The next address then starts a new wait sequence.
- Unmapped access (no `hit_i`, read or write, in a cycle with `RDY` = 1):
  - sets `bus_err`;
  - loads `err_addr` only if `bus_err` was 0, so the first error is kept.
- `err_clr` clears `bus_err` and leaves `err_addr` as is. If `err_clr` and a new unmapped access occur in the same cycle, the error wins: `bus_err` = 1 and `err_addr` = the new address.

## Timing
- Reset values: `rd_sel` = 0, `DI` = `DEFAULT_DATA`, `RDY` = 1, `bus_err` = 0, `err_addr` = 0, FSM = IDLE, `cnt` = 0.
- `cs` appears in the same cycle as `AB`. Peripheral data is taken by the CPU one cycle after the final address cycle, via `rd_sel`/`DI`.
- Zero-wait read latency: address cycle T, `DI` valid in T+1.
- W-wait read latency: address held T..T+W with `RDY` low T..T+W−1; `DI` valid in T+W+1.
- While `reset` is asserted, `RDY` = 1 and `cs` still decodes; no FSM transition happens.
- `reset` during WAIT aborts the wait: IDLE on the next cycle, with `RDY` = 1 in that same reset cycle.
- `WAIT_i` = 15 is the maximum: 15 stall cycles, no counter wrap.

## Test plan
- `BASE`/`MASK` = AA00/FE00, CC10/FFFF, CC20/FFFE, FFFC/FFFC, all W = 0; read AA05 → `cs`=0001, `RDY` stays 1, next cycle `rd_sel`=0001 and `DI`=`rd_data[7:0]`.
- Region 2 with W = 3; read CC21 → `RDY` low exactly 3 cycles, high on the 4th; `DI` = region 2 data on the 5th. Then an immediate read CC20 → another 3-cycle stall.
- W = 1 read followed by a write to the same region → 1 stall cycle on the read, 0 on the write, `rd_sel` = 0 after the write.
- Read 1234 then write 5678 (both unmapped) → `bus_err` = 1, `err_addr` = 1234, `DI` = FF. Then `err_clr` together with unmapped 4321 → `bus_err` = 1, `err_addr` = 4321.
- Overlap: region 0 = 0000/0000 (matches everything), region 1 = CC10/FFFF; read CC10 → `cs` = 0001, region 0 wins.
- Assert `reset` in the 2nd cycle of a W = 5 stall → `RDY` = 1 immediately, FSM IDLE, `rd_sel` = 0, `bus_err` = 0 after reset.
